// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, NOP encoding,
// default reset vector and the fetch FIFO entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR_DFLT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer prefetch FIFO of {pc, instr} entries with a synchronous
// flush. Pointers wrap naturally; count is one bit wider than the pointers.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_din,
  output fetch_entry_t o_dout,
  output logic [AW:0]  o_count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Pointer and occupancy state; flush behaves exactly like reset.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW + 1){1'b0}};
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_reset && !i_flush) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one-cycle-latency imem reads under a credit
// limit, buffers returns and hands {pc, instr} to decode. FETCH_PERF_CNT_EN adds perf counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              FIFO_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DFLT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_pc,
  output logic [31:0]     o_id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_flushed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_used;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_din;
  fetch_entry_t    w_head;

  // Credit counts words already buffered plus the one still in flight.
  assign w_used      = w_count + {{(CW - 1){1'b0}}, r_inflight};
  assign o_imem_req  = !i_reset && !i_redirect_valid && (w_used < DEPTH_C);
  assign o_imem_addr = r_pc;
  assign w_push      = r_inflight && !i_redirect_valid;
  assign w_pop       = o_id_valid && i_id_ready;
  assign w_din       = '{pc: r_inflight_pc, instr: i_imem_rdata};

  // PC and in-flight tag; redirect overrides issue and kills the pending read.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_VECTOR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_VECTOR;
    end else if (i_redirect_valid) begin
      r_pc       <= {i_redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_imem_req;
      if (o_imem_req) begin
        r_pc          <= r_pc + PC_STEP;
        r_inflight_pc <= r_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  // Decode view of the FIFO head; an empty FIFO presents a NOP.
  always_comb begin
    o_id_valid = 1'b0;
    o_id_pc    = RESET_VECTOR;
    o_id_instr = INSTR_NOP;
    if (w_count != {CW{1'b0}}) begin
      o_id_valid = 1'b1;
      o_id_pc    = w_head.pc;
      o_id_instr = w_head.instr;
    end else begin
      o_id_valid = 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   r_perf_fetched;
  logic [31:0]   r_perf_flushed;
  logic [CW-1:0] w_dropped;

  // An entry popped in the redirect cycle was consumed, not flushed.
  assign w_dropped = w_used - {{(CW - 1){1'b0}}, w_pop};

  // Retired-fetch and flushed-word counters, wrapping modulo 2^32.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_fetched <= 32'd0;
      r_perf_flushed <= 32'd0;
    end else begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (i_redirect_valid) begin
        r_perf_flushed <= r_perf_flushed + {{(32 - CW){1'b0}}, w_dropped};
      end
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_flushed = r_perf_flushed;
`endif

endmodule
